// File: rtl/l1_l2_arbiter_pkg.sv
// Shared LC-3b memory-side types: word/line widths and the L1->L2 arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cache_line;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en_i,
    output lc3b_word count_o
);

    lc3b_word count_q;
    lc3b_word count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares one L2 port between the icache and dcache; ties alternate via last_grant,
// and a one-cycle DONE gap lets the winner retire its request before re-arbitration.
module l1_l2_arbiter
    import lc3b_types::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,

    input  lc3b_word       icache_address,
    input  logic           icache_read,
    input  logic           icache_write,
    input  lc3b_cache_line icache_wdata,
    output lc3b_cache_line icache_rdata,
    output logic           icache_mem_resp,

    input  lc3b_word       dcache_address,
    input  logic           dcache_read,
    input  logic           dcache_write,
    input  lc3b_cache_line dcache_wdata,
    output lc3b_cache_line dcache_rdata,
    output logic           dcache_mem_resp,

    input  lc3b_cache_line l2_rdata,
    input  logic           l2_mem_resp,
    output lc3b_word       l2_address,
    output lc3b_cache_line l2_wdata,
    output logic           l2_read,
    output logic           l2_write,

    output lc3b_word       icache_grants,
    output lc3b_word       dcache_grants
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       i_pend, d_pend;
    logic       grant_i, grant_d;

    assign i_pend = icache_read | icache_write;
    assign d_pend = dcache_read | dcache_write;

    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        l2_address      = '0;
        l2_wdata        = '0;
        l2_read         = 1'b0;
        l2_write        = 1'b0;
        icache_mem_resp = 1'b0;
        dcache_mem_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                // icache wins when alone, or on a tie when dcache was served last
                if (i_pend && (!d_pend || (last_grant_q == GRANT_D))) begin
                    state_d      = BUSY_I;
                    last_grant_d = GRANT_I;
                    grant_i      = 1'b1;
                end else if (d_pend) begin
                    state_d      = BUSY_D;
                    last_grant_d = GRANT_D;
                    grant_d      = 1'b1;
                end
            end
            BUSY_I: begin
                l2_address = icache_address;
                l2_wdata   = icache_wdata;
                l2_write   = icache_write;
                l2_read    = icache_read & ~icache_write;
                if (!i_pend) begin
                    state_d = IDLE;
                end else if (l2_mem_resp) begin
                    icache_mem_resp = 1'b1;
                    state_d         = DONE;
                end
            end
            BUSY_D: begin
                l2_address = dcache_address;
                l2_wdata   = dcache_wdata;
                l2_write   = dcache_write;
                l2_read    = dcache_read & ~dcache_write;
                if (!d_pend) begin
                    state_d = IDLE;
                end else if (l2_mem_resp) begin
                    dcache_mem_resp = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs drop the instant reset asserts, not just after the state register clears
        if (!rst_n) begin
            l2_read         = 1'b0;
            l2_write        = 1'b0;
            icache_mem_resp = 1'b0;
            dcache_mem_resp = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ~D_FIRST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    sat_counter16 u_icache_grants (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (grant_i),
        .count_o (icache_grants)
    );

    sat_counter16 u_dcache_grants (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (grant_d),
        .count_o (dcache_grants)
    );

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Scoreboard bench for l1_l2_arbiter: expected L2 transactions queued at request time, checked at grant.
module tb_l1_l2_arbiter;
    import lc3b_types::*;

    typedef struct {
        logic           who;
        lc3b_word       addr;
        lc3b_cache_line wdata;
        logic           rd;
        logic           wr;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst_n;
    lc3b_word       icache_address, dcache_address, l2_address;
    logic           icache_read, icache_write, dcache_read, dcache_write;
    lc3b_cache_line icache_wdata, dcache_wdata, icache_rdata, dcache_rdata;
    logic           icache_mem_resp, dcache_mem_resp;
    lc3b_cache_line l2_rdata, l2_wdata;
    logic           l2_mem_resp, l2_read, l2_write;
    lc3b_word       icache_grants, dcache_grants;

    logic           cnt_rst_n, cnt_en;
    lc3b_word       cnt_q;

    int  n_cmp = 0;
    int  n_err = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    l1_l2_arbiter #(.D_FIRST(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icache_address  (icache_address),
        .icache_read     (icache_read),
        .icache_write    (icache_write),
        .icache_wdata    (icache_wdata),
        .icache_rdata    (icache_rdata),
        .icache_mem_resp (icache_mem_resp),
        .dcache_address  (dcache_address),
        .dcache_read     (dcache_read),
        .dcache_write    (dcache_write),
        .dcache_wdata    (dcache_wdata),
        .dcache_rdata    (dcache_rdata),
        .dcache_mem_resp (dcache_mem_resp),
        .l2_rdata        (l2_rdata),
        .l2_mem_resp     (l2_mem_resp),
        .l2_address      (l2_address),
        .l2_wdata        (l2_wdata),
        .l2_read         (l2_read),
        .l2_write        (l2_write),
        .icache_grants   (icache_grants),
        .dcache_grants   (dcache_grants)
    );

    sat_counter16 u_cnt (
        .clk     (clk),
        .rst_n   (cnt_rst_n),
        .en_i    (cnt_en),
        .count_o (cnt_q)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic who, input lc3b_word a, input lc3b_cache_line wd,
                        input logic rd, input logic wr);
        sb_t e;
        e.who = who; e.addr = a; e.wdata = wd; e.rd = rd; e.wr = wr;
        sb.push_back(e);
    endtask

    // Wait for a grant, compare it with the queue head, respond after lat cycles,
    // and return in the DONE cycle so the caller can change requests.
    task automatic serve(input int lat, input lc3b_cache_line rdat, output logic who, output int waited);
        sb_t e;
        waited = 0;
        who    = 1'b0;
        while (!(l2_read | l2_write) && waited < 10) begin
            step();
            waited++;
        end
        if (!(l2_read | l2_write)) begin
            chk("grant_timeout", {127'd0, l2_read | l2_write}, 128'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 128'd1);
            return;
        end
        e   = sb.pop_front();
        who = e.who;
        chk("l2_address", l2_address, e.addr);
        if (e.wr) chk("l2_wdata", l2_wdata, e.wdata);
        chk("l2_read", l2_read, e.rd & ~e.wr);
        chk("l2_write", l2_write, e.wr);
        chk("resp_early", {icache_mem_resp, dcache_mem_resp}, 128'd0);
        repeat (lat) step();
        l2_mem_resp = 1'b1;
        l2_rdata    = rdat;
        #1;
        chk("icache_mem_resp", icache_mem_resp, e.who == 1'b0);
        chk("dcache_mem_resp", dcache_mem_resp, e.who == 1'b1);
        chk("rdata", e.who ? dcache_rdata : icache_rdata, rdat);
        step();
        l2_mem_resp = 1'b0;
        #1;
        chk("done_quiet", {l2_read, l2_write, icache_mem_resp, dcache_mem_resp}, 128'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic who;
        int   waited;
        logic exp_order [4];

        rst_n = 1'b0; cnt_rst_n = 1'b0; cnt_en = 1'b0;
        icache_address = '0; icache_read = 1'b0; icache_write = 1'b0; icache_wdata = '0;
        dcache_address = '0; dcache_read = 1'b0; dcache_write = 1'b0; dcache_wdata = '0;
        l2_rdata = '0; l2_mem_resp = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst_icache_grants", icache_grants, 128'd0);
        chk("rst_dcache_grants", dcache_grants, 128'd0);
        chk("rst_l2_rw", {l2_read, l2_write}, 128'd0);
        chk("rst_resp", {icache_mem_resp, dcache_mem_resp}, 128'd0);
        rst_n = 1'b1;
        step();

        // Single icache read, L2 answers 3 cycles after the grant
        icache_address = 16'h1230; icache_read = 1'b1;
        push(1'b0, 16'h1230, '0, 1'b1, 1'b0);
        serve(3, {4{32'hCAFE_0001}}, who, waited);
        chk("latency_first", waited, 128'd1);
        chk("icache_grants_1", icache_grants, 128'd1);
        icache_read = 1'b0;
        step();
        chk("dcache_grants_0", dcache_grants, 128'd0);

        // dcache write, then read+write together (write wins)
        dcache_address = 16'h4000; dcache_write = 1'b1; dcache_wdata = {16{8'hA5}};
        push(1'b1, 16'h4000, {16{8'hA5}}, 1'b0, 1'b1);
        serve(1, {4{32'h1111_2222}}, who, waited);
        dcache_address = 16'h4010; dcache_read = 1'b1; dcache_wdata = {16{8'h5A}};
        push(1'b1, 16'h4010, {16{8'h5A}}, 1'b1, 1'b1);
        serve(1, {4{32'h3333_4444}}, who, waited);
        dcache_read = 1'b0; dcache_write = 1'b0;
        step();
        chk("dcache_grants_2", dcache_grants, 128'd2);

        // icache drops its request mid-transaction, then a stray response in IDLE
        icache_address = 16'h2000; icache_read = 1'b1;
        step();
        chk("drop_busy_read", l2_read, 128'd1);
        icache_read = 1'b0; l2_mem_resp = 1'b1;
        #1;
        chk("drop_l2_read", l2_read, 128'd0);
        chk("drop_no_resp", icache_mem_resp, 128'd0);
        step();
        chk("stray_resp", {icache_mem_resp, dcache_mem_resp}, 128'd0);
        chk("icache_grants_2", icache_grants, 128'd2);
        step();
        chk("stray_state", {l2_read, l2_write}, 128'd0);
        chk("stray_grants", {icache_grants, dcache_grants}, {96'd0, 16'd2, 16'd2});
        l2_mem_resp = 1'b0;

        // Reset while BUSY_D aborts the write with no response
        dcache_address = 16'h5000; dcache_write = 1'b1; dcache_wdata = {4{32'hDEAD_BEEF}};
        step();
        chk("busy_d_write", l2_write, 128'd1);
        l2_mem_resp = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst_mid_write", l2_write, 128'd0);
        chk("rst_mid_resp", dcache_mem_resp, 128'd0);
        chk("rst_mid_grants", dcache_grants, 128'd0);
        step();
        rst_n = 1'b1; l2_mem_resp = 1'b0;
        dcache_write = 1'b0; dcache_read = 1'b1; dcache_address = 16'h5100;
        push(1'b1, 16'h5100, '0, 1'b1, 1'b0);
        serve(2, {4{32'h0BAD_F00D}}, who, waited);
        dcache_read = 1'b0;
        step();
        chk("post_rst_grants", dcache_grants, 128'd1);

        // Four back-to-back ties from a fresh reset: D, I, D, I
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        dcache_address = 16'hD000; dcache_read = 1'b1;
        icache_address = 16'h1000; icache_read = 1'b1;
        push(1'b1, 16'hD000, '0, 1'b1, 1'b0);
        push(1'b0, 16'h1000, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            serve(1, {4{k[31:0]}}, who, waited);
            chk("tie_order", who, exp_order[k]);
            chk("tie_spacing", waited, (k == 0) ? 128'd1 : 128'd2);
            if (who) begin
                dcache_address = dcache_address + 16'd1;
                push(1'b1, dcache_address, '0, 1'b1, 1'b0);
            end else begin
                icache_address = icache_address + 16'd1;
                push(1'b0, icache_address, '0, 1'b1, 1'b0);
            end
        end
        icache_read = 1'b0; dcache_read = 1'b0;
        sb.delete();
        repeat (2) step();
        chk("tie_grants", {icache_grants, dcache_grants}, {96'd0, 16'd2, 16'd2});

        // Saturation of the grant counter over 70000 enables
        cnt_rst_n = 1'b1; cnt_en = 1'b1;
        repeat (65534) step();
        chk("sat_fffe", cnt_q, 128'hFFFE);
        step();
        chk("sat_ffff", cnt_q, 128'hFFFF);
        repeat (4466) step();
        chk("sat_hold", cnt_q, 128'hFFFF);
        cnt_en = 1'b0;
        chk("sat_dcache_unaffected", dcache_grants, 128'd2);
        cnt_rst_n = 1'b0;
        #1;
        chk("sat_clear", cnt_q, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

Interface
REQ-001 Parameter: D_FIRST, default 1, selects the reset value of last_grant (1: dcache wins the first tie; 0: icache wins it).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 icache_address, icache_read, icache_write, icache_wdata  in  16/1/1/128  icache line request, held stable until icache_mem_resp.
REQ-006 icache_rdata  out  128; icache_mem_resp  out  1  line data and one-cycle completion to icache.
REQ-007 dcache_address, dcache_read, dcache_write, dcache_wdata  in  16/1/1/128  dcache line request, same hold rule.
REQ-008 dcache_rdata  out  128; dcache_mem_resp  out  1  line data and one-cycle completion to dcache.
REQ-009 l2_rdata  in  128; l2_mem_resp  in  1  L2 line data and one-cycle completion.
REQ-010 l2_address  out  16; l2_wdata  out  128; l2_read, l2_write  out  1  L2 request, held until l2_mem_resp.
REQ-011 icache_grants, dcache_grants  out  16  saturating grant counters.

Function
REQ-012 FSM states SHALL be IDLE, BUSY_I, BUSY_D and DONE, plus a 1-bit last_grant register (0 = icache, 1 = dcache).
REQ-013 A requester is pending when its read or its write is high.
REQ-014 In IDLE with exactly one requester pending, the FSM SHALL enter that requester's BUSY state on the next edge.
REQ-015 In IDLE with both requesters pending, the FSM SHALL grant the requester not equal to last_grant, and SHALL update last_grant to the requester just granted.
REQ-016 In IDLE with no requester pending, the FSM SHALL remain in IDLE, and all L2 and response outputs SHALL be 0.
REQ-017 In BUSY_x, l2_address, l2_wdata, l2_read and l2_write SHALL combinationally mirror requester x; the other requester SHALL see mem_resp = 0.
REQ-018 If requester x asserts read and write together, l2_write SHALL be 1 and l2_read SHALL be 0.
REQ-019 In BUSY_x with l2_mem_resp = 1, x_mem_resp SHALL be 1 in the same cycle, and the next state SHALL be DONE.
REQ-020 icache_rdata and dcache_rdata SHALL both equal l2_rdata at all times.
REQ-021 DONE SHALL last exactly one cycle, with all L2 requests and responses at 0, then go to IDLE.
REQ-022 The DONE cycle lets the requester drop or change its request before re-arbitration; back-to-back grants are therefore spaced at least 2 cycles after a response.
REQ-023 Latency: a request seen in IDLE at cycle N drives L2 from cycle N+1; the response is zero-latency pass-through of l2_mem_resp.
REQ-024 If requester x drops both read and write while in BUSY_x, the FSM SHALL return to IDLE next cycle, assert no response, and deassert the L2 request that cycle.
REQ-025 l2_mem_resp arriving in IDLE or DONE SHALL be ignored.
REQ-026 A grant counter SHALL increment by 1 on each IDLE-to-BUSY transition for its requester, and SHALL saturate at 0xFFFF with no wrap.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, last_grant = D_FIRST ? 0 : 1 (so the D_FIRST side wins the first tie), both counters 0x0000.
REQ-028 rst_n low SHALL immediately force l2_read, l2_write, icache_mem_resp and dcache_mem_resp to 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no response; after release, arbitration restarts from IDLE.

Structure
REQ-030 lc3b_word (16 bits), lc3b_cache_line (128 bits) and the state enum SHALL live in the shared package lc3b_types.
REQ-031 A sub-module sat_counter16 (enable, async active-low clear, saturating) SHALL implement both grant counters.
REQ-032 The FSM and L2 output mux SHALL be a single always_ff plus always_comb pair.

Verification
REQ-033 Reset release; icache read of 0x1230 only; L2 responds after 3 cycles -> l2_read high from cycle 1; icache_mem_resp is one pulse coincident with l2_mem_resp; icache_grants = 1.
REQ-034 D_FIRST = 1; both caches request at cycle 0 -> dcache granted first, then icache after DONE; grant order over four back-to-back ties is D, I, D, I.
REQ-035 dcache write of 0x4000 with wdata 128'hA5...A5 -> l2_write = 1, l2_wdata matches, l2_read = 0, dcache_mem_resp = 1 on response; with read and write both high, l2_write wins.
REQ-036 rst_n pulsed low while in BUSY_D -> l2_write drops in the same cycle; no dcache_mem_resp; next request is serviced normally.
REQ-037 Force 70000 icache grants -> icache_grants holds at 0xFFFF; dcache_grants is unaffected.
REQ-038 Stray l2_mem_resp in IDLE -> no mem_resp and no state change.
